rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 Parameter HOLD_MAX, default 16, maximum consecutive grant cycles per holder while others wait; 0 = unlimited.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  synchronous active-high reset; asserted at 1, sampled on rising clk.
REQ-005 Port m_req  input  NUM_MASTERS  per-master request level, held high while access wanted.
REQ-006 Port m_grant  output  NUM_MASTERS  registered one-hot grant, all-zero when idle.
REQ-007 Port grant_id  output  max(1,clog2(NUM_MASTERS))  registered index of current holder, 0 when idle.
REQ-008 Port grant_valid  output  1  registered, high iff m_grant nonzero.

Function
REQ-009 FSM states SHALL be ARB_IDLE (no grant) and ARB_GRANT (exactly one grant).
REQ-010 m_grant SHALL never have more than one bit set in any cycle.
REQ-011 ARB_IDLE: m_req all zero -> stay ARB_IDLE; any bit set -> ARB_GRANT, grant to round-robin winner at next edge (1-cycle request-to-grant latency).
REQ-012 Round-robin winner SHALL be the first requesting index searched upward from (last_holder+1) mod NUM_MASTERS, wrapping.
REQ-013 last_holder SHALL update to the new holder index on every grant change.
REQ-014 ARB_GRANT, holder m_req high, hold limit not reached: grant unchanged.
REQ-015 ARB_GRANT, holder m_req low, other requests pending: handover at next edge to RR winner, no idle cycle inserted.
REQ-016 ARB_GRANT, holder m_req low, no other requests: ARB_IDLE and m_grant all zero at next edge.
REQ-017 Hold counter SHALL count cycles in ARB_GRANT for current holder, cleared on each grant change or entry to ARB_GRANT.
REQ-018 HOLD_MAX>0, counter reaches HOLD_MAX, another master requesting: forced handover at next edge to RR winner excluding holder.
REQ-019 HOLD_MAX reached, no other master requesting: holder keeps grant; counter saturates at HOLD_MAX.
REQ-020 Holder dropping m_req in the same cycle hold limit is reached SHALL be treated as REQ-015/REQ-016.
REQ-021 Preempted holder still requesting SHALL remain a candidate and regain grant in RR order.
REQ-022 Counter width SHALL be clog2(HOLD_MAX+1) bits, no wrap.

Reset
REQ-023 reset_n=1 at rising edge: state ARB_IDLE, m_grant 0, grant_id 0, grant_valid 0, hold counter 0, last_holder NUM_MASTERS-1 (so master 0 wins first).
REQ-024 Reset mid-grant SHALL drop grant at that edge regardless of m_req; arbitration resumes the cycle after reset_n deasserts.
REQ-025 m_req SHALL be ignored while reset_n=1.

Structure
REQ-026 Shared package arbiter_pkg SHALL hold state encoding constants ARB_IDLE/ARB_GRANT and defaults for NUM_MASTERS and HOLD_MAX.
REQ-027 One sub-module rr_pick (combinational: req vector, start pointer -> winner index, found flag) SHALL implement REQ-012.
REQ-028 All outputs SHALL be driven directly from flops; no combinational path m_req -> m_grant.

Verification
REQ-029 Reset then m_req=4'b0000 for 5 cycles -> m_grant=0, grant_valid=0 throughout.
REQ-030 m_req=4'b1010 from idle -> next edge m_grant=4'b0010, grant_id=1; drop bit1 -> next edge m_grant=4'b1000, grant_id=3, no gap.
REQ-031 m_req=4'b1111 held, HOLD_MAX=4 -> grants rotate 0,1,2,3,0 every 5 cycles (4 hold + handover edge).
REQ-032 m_req=4'b0100 held 40 cycles, HOLD_MAX=16 -> m_grant=4'b0100 continuously, counter saturated at 16.
REQ-033 Master 2 granted, reset_n pulsed 1 cycle while m_req=4'b0100 -> m_grant=0 at reset edge, regranted 4'b0100 one cycle after release.
REQ-034 All m_req drop in one cycle while granted -> next edge m_grant=0, grant_valid=0, state ARB_IDLE; one-hot assertion checked every cycle.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_pkg
//  Description : Shared state encoding and parameter defaults for rr_arbiter.
//  Revision    : 1.0
// ============================================================================
package arbiter_pkg;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_HOLD_MAX    = 16;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index width, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin search: first set request at or
//                above start_i, wrapping, with found flag.
//  Revision    : 1.0
// ============================================================================
module rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [ID_W-1:0]        start_i,
  output logic [ID_W-1:0]        winner_o,
  output logic                   found_o
);

  logic [2*NUM_MASTERS-1:0] w_dbl;
  logic [NUM_MASTERS-1:0]   w_rot;
  logic [ID_W:0]            w_sum;

  // Rotating a doubled vector puts start_i at bit 0 so a plain
  // lowest-set-bit search yields the wrapped round-robin order.
  assign w_dbl = {req_i, req_i};
  assign w_rot = NUM_MASTERS'(w_dbl >> start_i);

  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    w_sum    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found_o && w_rot[i]) begin
        found_o = 1'b1;
        w_sum   = {1'b0, start_i} + (ID_W+1)'(i);
        if (w_sum >= (ID_W+1)'(NUM_MASTERS)) begin
          w_sum = w_sum - (ID_W+1)'(NUM_MASTERS);
        end
        winner_o = w_sum[ID_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Registered round-robin arbiter with optional per-holder
//                hold limit and forced handover.
//  Revision    : 1.0
// ============================================================================
module rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int HOLD_MAX    = DEF_HOLD_MAX
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_MASTERS-1:0]                m_req,
  output logic [NUM_MASTERS-1:0]                m_grant,
  output logic [id_width(NUM_MASTERS)-1:0]      grant_id,
  output logic                                  grant_valid
);

  localparam int ID_W  = id_width(NUM_MASTERS);
  localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_MAX);
  localparam logic [ID_W-1:0]  C_LAST = ID_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic                   valid_q, valid_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;

  logic [ID_W-1:0]        w_start;
  logic [NUM_MASTERS-1:0] w_cand;
  logic [ID_W-1:0]        w_winner;
  logic                   w_found;
  logic                   w_holder_req;
  logic                   w_limit;

  assign w_start = (last_q == C_LAST) ? '0 : last_q + 1'b1;
  // The holder is never its own candidate, so a forced handover skips it.
  assign w_cand       = (state_q == ARB_GRANT) ? (m_req & ~grant_q) : m_req;
  assign w_holder_req = |(m_req & grant_q);
  assign w_limit      = (HOLD_MAX > 0) && (hold_cnt_q == C_HOLD);

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .ID_W        (ID_W)
  ) u_pick (
    .req_i    (w_cand),
    .start_i  (w_start),
    .winner_o (w_winner),
    .found_o  (w_found)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    id_d       = id_q;
    valid_d    = valid_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;

    if (w_found && ((state_q == ARB_IDLE) || !w_holder_req || w_limit)) begin
      state_d    = ARB_GRANT;
      grant_d    = NUM_MASTERS'(1) << w_winner;
      id_d       = w_winner;
      valid_d    = 1'b1;
      last_d     = w_winner;
      hold_cnt_d = '0;
    end else if ((state_q == ARB_GRANT) && !w_holder_req) begin
      state_d    = ARB_IDLE;
      grant_d    = '0;
      id_d       = '0;
      valid_d    = 1'b0;
      hold_cnt_d = '0;
    end else if ((state_q == ARB_GRANT) && (HOLD_MAX > 0) && !w_limit) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      id_q       <= '0;
      valid_q    <= 1'b0;
      last_q     <= C_LAST;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      id_q       <= id_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign m_grant     = grant_q;
  assign grant_id    = id_q;
  assign grant_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter
//  Description : Directed self-checking bench for rr_arbiter (HOLD_MAX 16/4).
//  Revision    : 1.0
// ============================================================================
module tb_rr_arbiter;
  import arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] m_req = 4'b0000;

  logic [3:0] g16, g4;
  logic [1:0] id16, id4;
  logic       v16, v4;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_MASTERS(4), .HOLD_MAX(16)) dut16 (
    .clk         (clk),
    .reset_n     (reset_n),
    .m_req       (m_req),
    .m_grant     (g16),
    .grant_id    (id16),
    .grant_valid (v16)
  );

  rr_arbiter #(.NUM_MASTERS(4), .HOLD_MAX(4)) dut4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .m_req       (m_req),
    .m_grant     (g4),
    .grant_id    (id4),
    .grant_valid (v4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant must be at most one-hot and agree with grant_valid every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($onehot0(g16) && $onehot0(g4) && (v16 === (g16 != 4'b0)) && (v4 === (g4 != 4'b0)))
      else begin
        errors++;
        $error("FAIL onehot observed=%0h/%0h expected=onehot0", g16, g4);
      end
    end
  end

  initial begin
    tick();
    tick();
    chk("rst_grant", 32'(g16), 32'h0);
    chk("rst_id",    32'(id16), 32'h0);
    chk("rst_valid", 32'(v16), 32'h0);
    chk("rst_state", 32'(dut16.state_q), 32'(ARB_IDLE));
    chk("rst_cnt",   32'(dut16.hold_cnt_q), 32'h0);
    mon_en = 1'b1;

    reset_n = 1'b0;
    m_req   = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_grant", 32'(g16), 32'h0);
      chk("idle_valid", 32'(v16), 32'h0);
    end

    // First winner after reset from 1010 is master 1, then handover to 3.
    m_req = 4'b1010;
    tick();
    chk("first_grant", 32'(g16), 32'h2);
    chk("first_id",    32'(id16), 32'h1);
    chk("first_valid", 32'(v16), 32'h1);
    m_req = 4'b1000;
    tick();
    chk("handover_grant", 32'(g16), 32'h8);
    chk("handover_id",    32'(id16), 32'h3);
    m_req = 4'b0000;
    tick();
    chk("drop_grant", 32'(g16), 32'h0);
    chk("drop_valid", 32'(v16), 32'h0);

    // All requesting with HOLD_MAX=4: each holder keeps 5 cycles.
    m_req = 4'b1111;
    tick();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        chk("rotate_grant", 32'(g4), 32'(1) << (r % 4));
        chk("rotate_id",    32'(id4), 32'(r % 4));
        tick();
      end
    end
    m_req = 4'b0000;
    tick();
    chk("rot_end_grant16", 32'(g16), 32'h0);
    chk("rot_end_grant4",  32'(g4), 32'h0);

    // Lone requester keeps the grant and the counter saturates.
    m_req = 4'b0100;
    tick();
    for (int i = 0; i < 40; i++) begin
      chk("sat_grant16", 32'(g16), 32'h4);
      chk("sat_grant4",  32'(g4), 32'h4);
      tick();
    end
    chk("sat_cnt16", 32'(dut16.hold_cnt_q), 32'd16);
    chk("sat_cnt4",  32'(dut4.hold_cnt_q), 32'd4);
    chk("sat_id",    32'(id16), 32'h2);

    // Reset pulse mid-grant drops grant; regrant one cycle after release.
    reset_n = 1'b1;
    tick();
    chk("rstmid_grant", 32'(g16), 32'h0);
    chk("rstmid_valid", 32'(v16), 32'h0);
    chk("rstmid_id",    32'(id16), 32'h0);
    reset_n = 1'b0;
    tick();
    chk("regrant_grant", 32'(g16), 32'h4);
    chk("regrant_id",    32'(id16), 32'h2);
    chk("regrant_cnt",   32'(dut16.hold_cnt_q), 32'h0);

    // All requests vanish at once.
    m_req = 4'b0000;
    tick();
    chk("alldrop_grant", 32'(g16), 32'h0);
    chk("alldrop_valid", 32'(v16), 32'h0);
    chk("alldrop_state", 32'(dut16.state_q), 32'(ARB_IDLE));
    tick();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
